// File: rtl/eedc_pkg.sv
// Shared widths, codeword layout and types for the EEDC Hamming(11,7) path.
// Positions are 1-based codeword positions; bit k of a code_t holds position k+1.
package eedc_pkg;

    localparam int unsigned DATA_W = 7;
    localparam int unsigned CODE_W = 11;
    localparam int unsigned PAR_W  = 4;

    // Parity bits live at the power-of-two positions
    localparam int unsigned POS_P1 = 1;
    localparam int unsigned POS_P2 = 2;
    localparam int unsigned POS_P4 = 4;
    localparam int unsigned POS_P8 = 8;

    // Data bits fill the remaining positions in ascending order
    localparam int unsigned POS_D0 = 3;
    localparam int unsigned POS_D1 = 5;
    localparam int unsigned POS_D2 = 6;
    localparam int unsigned POS_D3 = 7;
    localparam int unsigned POS_D4 = 9;
    localparam int unsigned POS_D5 = 10;
    localparam int unsigned POS_D6 = 11;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CODE_W-1:0] code_t;

    // Data bits covered by each parity bit: those whose position has the
    // parity bit's position bit set (d6..d0, MSB first)
    localparam data_t COVER_P1 = 7'b1011011;  // pos 3,5,7,9,11
    localparam data_t COVER_P2 = 7'b1101101;  // pos 3,6,7,10,11
    localparam data_t COVER_P4 = 7'b0001110;  // pos 5,6,7
    localparam data_t COVER_P8 = 7'b1110000;  // pos 9,10,11

    // Even parity over the covered data bits
    function automatic logic cover_parity(data_t data, data_t mask);
        return ^(data & mask);
    endfunction

endpackage

// File: rtl/hamming_11_7_gen.sv
// Combinational Hamming(11,7) even-parity codeword generator.
module hamming_11_7_gen
    import eedc_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CODE_W-1:0] code_o
);

    code_t code;

    // Place data bits at their positions, then fill in the four parity bits
    always_comb begin
        code             = '0;
        code[POS_D0 - 1] = data_i[0];
        code[POS_D1 - 1] = data_i[1];
        code[POS_D2 - 1] = data_i[2];
        code[POS_D3 - 1] = data_i[3];
        code[POS_D4 - 1] = data_i[4];
        code[POS_D5 - 1] = data_i[5];
        code[POS_D6 - 1] = data_i[6];
        code[POS_P1 - 1] = cover_parity(data_i, COVER_P1);
        code[POS_P2 - 1] = cover_parity(data_i, COVER_P2);
        code[POS_P4 - 1] = cover_parity(data_i, COVER_P4);
        code[POS_P8 - 1] = cover_parity(data_i, COVER_P8);
    end

    assign code_o = code;

endmodule

// File: rtl/eedc_encoder.sv
// Registered Hamming(11,7) encoder, one word per cycle, 1-cycle latency.
// Optional macro EEDC_SECDED_EN adds a registered overall_parity output
// (XOR of all 11 codeword bits) for 12-bit extended-Hamming SECDED.
module eedc_encoder
    import eedc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_input,
    output logic [CODE_W-1:0] encoded_output,
    output logic              out_valid
`ifdef EEDC_SECDED_EN
    ,
    output logic              overall_parity
`endif
);

    code_t code_gen;
    code_t code_d, code_q;
    logic  valid_d, valid_q;

    hamming_11_7_gen u_gen (
        .data_i (data_input),
        .code_o (code_gen)
    );

    // Next state: capture every cycle; valid sticks once out of reset
    always_comb begin
        code_d  = code_gen;
        valid_d = 1'b1;
    end

    // Output registers; synchronous reset wins over capture
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign encoded_output = code_q;
    assign out_valid      = valid_q;

`ifdef EEDC_SECDED_EN
    logic opar_d, opar_q;

    // Overall parity of the fresh codeword, aligned with code_q
    always_comb begin
        opar_d = ^code_gen;
    end

    // Overall parity register, same reset and latency as the codeword
    always_ff @(posedge clk) begin
        if (rst) begin
            opar_q <= 1'b0;
        end else begin
            opar_q <= opar_d;
        end
    end

    assign overall_parity = opar_q;
`endif

endmodule

// File: tb/tb_eedc_encoder.sv
// Directed self-checking bench for eedc_encoder (Hamming(11,7), optional SECDED).
module tb_eedc_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  data_input;
    logic [10:0] encoded_output;
    logic        out_valid;
`ifdef EEDC_SECDED_EN
    logic        overall_parity;
`endif

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    eedc_encoder dut (
        .clk            (clk),
        .rst            (rst),
        .data_input     (data_input),
        .encoded_output (encoded_output),
        .out_valid      (out_valid)
`ifdef EEDC_SECDED_EN
        ,
        .overall_parity (overall_parity)
`endif
    );

    always #5 clk = ~clk;

    // Hand-computed directed vectors: data, codeword, overall parity
    logic [6:0]  tv_d [7] = '{7'h01, 7'h02, 7'h04, 7'h10, 7'h03, 7'h7F, 7'h00};
    logic [10:0] tv_c [7] = '{11'b00000000111, 11'b00000011001, 11'b00000101010,
                              11'b00110000001, 11'b00000011110, 11'h7FF, 11'h000};
    logic        tv_p [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference codeword straight from the position map and parity equations
    function automatic logic [10:0] ref_code(input logic [6:0] d);
        logic [10:0] c;
        c     = '0;
        c[2]  = d[0];
        c[4]  = d[1];
        c[5]  = d[2];
        c[6]  = d[3];
        c[8]  = d[4];
        c[9]  = d[5];
        c[10] = d[6];
        c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[3]  = d[1] ^ d[2] ^ d[3];
        c[7]  = d[4] ^ d[5] ^ d[6];
        return c;
    endfunction

    // XOR of the positions of all set bits; zero for a valid codeword
    function automatic logic [3:0] syndrome(input logic [10:0] c);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < 11; k++) begin
            if (c[k]) s ^= 4'(k + 1);
        end
        return s;
    endfunction

    initial begin
        logic [10:0] prev;
        logic [10:0] c;

        // Reset for two cycles with non-zero data present
        rst        = 1'b1;
        data_input = 7'h55;
        tick();
        tick();
        check_val("rst_code", 32'(encoded_output), 32'h0);
        check_val("rst_valid", 32'(out_valid), 32'h0);
`ifdef EEDC_SECDED_EN
        check_val("rst_opar", 32'(overall_parity), 32'h0);
`endif

        // Directed vectors; output must not change until the next edge
        rst  = 1'b0;
        prev = 11'h000;
        for (int i = 0; i < 7; i++) begin
            data_input = tv_d[i];
            #1;
            check_val("hold", 32'(encoded_output), 32'(prev));
            tick();
            check_val("dir_code", 32'(encoded_output), 32'(tv_c[i]));
            check_val("dir_valid", 32'(out_valid), 32'h1);
`ifdef EEDC_SECDED_EN
            check_val("dir_opar", 32'(overall_parity), 32'(tv_p[i]));
`endif
            prev = tv_c[i];
        end

        // Back-to-back stream 0..6
        for (int i = 0; i < 7; i++) begin
            data_input = 7'(i);
            tick();
            check_val("stream", 32'(encoded_output), 32'(ref_code(7'(i))));
        end

        // One-cycle reset mid-stream discards its data
        rst        = 1'b1;
        data_input = 7'h03;
        tick();
        check_val("mid_rst_code", 32'(encoded_output), 32'h0);
        check_val("mid_rst_valid", 32'(out_valid), 32'h0);
        rst        = 1'b0;
        data_input = 7'h04;
        tick();
        check_val("resume_code", 32'(encoded_output), 32'(ref_code(7'h04)));
        check_val("resume_valid", 32'(out_valid), 32'h1);

        // Exhaustive: model match, zero syndrome, single-flip syndromes
        for (int i = 0; i < 128; i++) begin
            data_input = 7'(i);
            tick();
            c = encoded_output;
            check_val("exh_code", 32'(c), 32'(ref_code(7'(i))));
            check_val("exh_syn0", 32'(syndrome(c)), 32'h0);
            for (int b = 0; b < 11; b++) begin
                check_val("exh_flip", 32'(syndrome(c ^ (11'b1 << b))), 32'(b + 1));
            end
`ifdef EEDC_SECDED_EN
            check_val("exh_opar", 32'(overall_parity), 32'(^ref_code(7'(i))));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
